// File: rtl/mvm_pkg.sv
// Shared types for the matrix-vector datapath: loader FSM states, frame size helper, operand typedefs.
// Pure declarations; no timing or flow control here.
package mvm_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAT_ROW    = 2;
  localparam int DEF_MAT_COL    = 2;

  function automatic int mvm_nm(input int rows, input int cols);
    return rows * cols;
  endfunction

  localparam int DEF_NM = mvm_nm(DEF_MAT_ROW, DEF_MAT_COL);

  typedef enum logic [1:0] {
    LOAD_MAT = 2'd0,
    LOAD_VEC = 2'd1,
    HOLD     = 2'd2
  } mvm_state_t;

  typedef logic [DEF_DATA_WIDTH-1:0] elem_t;
  typedef elem_t [DEF_MAT_COL-1:0] vec_t;
  typedef elem_t [DEF_MAT_ROW-1:0][DEF_MAT_COL-1:0] mat_t;

endpackage

// File: rtl/matrix_vector_loader.sv
// Packs a serial element stream into a register-held matrix + vector; out_valid one cycle after the last beat.
// in_ready/out_valid decode from state only; in_ready drops for the whole HOLD until out_ready handshakes.
module matrix_vector_loader
  import mvm_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAT_ROW    = 2,
  parameter int MAT_COL    = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [DATA_WIDTH-1:0]                      in_data,
  input  logic                                       in_valid,
  input  logic                                       in_last,
  output logic                                       in_ready,
  output logic [MAT_ROW-1:0][MAT_COL-1:0][DATA_WIDTH-1:0] mat,
  output logic [MAT_COL-1:0][DATA_WIDTH-1:0]         vec,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       frame_err
);

  localparam int NM = mvm_nm(MAT_ROW, MAT_COL);
  localparam int CW = $clog2(NM + 1);
  localparam logic [CW-1:0] MAT_LAST = CW'(NM - 1);
  localparam logic [CW-1:0] VEC_LAST = CW'(MAT_COL - 1);

  mvm_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic          final_beat;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);

  always_comb begin
    accept     = in_valid && in_ready;
    final_beat = (state_q == LOAD_VEC) && (cnt_q == VEC_LAST);
    state_d    = state_q;
    cnt_d      = cnt_q;
    case (state_q)
      LOAD_MAT: begin
        if (accept) begin
          if (cnt_q == MAT_LAST) begin
            state_d = LOAD_VEC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      LOAD_VEC: begin
        if (accept) begin
          if (cnt_q == VEC_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = LOAD_MAT;
      end
      default: begin
        state_d = LOAD_MAT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOAD_MAT;
      cnt_q     <= '0;
      mat       <= '0;
      vec       <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      // in_last is advisory only: flag any disagreement with the counter's idea of the frame end
      frame_err <= accept && (in_last != final_beat);
      if (accept && state_q == LOAD_MAT) begin
        for (int r = 0; r < MAT_ROW; r++) begin
          for (int c = 0; c < MAT_COL; c++) begin
            if (cnt_q == CW'(r * MAT_COL + c)) mat[r][c] <= in_data;
          end
        end
      end
      if (accept && state_q == LOAD_VEC) begin
        for (int j = 0; j < MAT_COL; j++) begin
          if (cnt_q == CW'(j)) vec[j] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_vector_loader.sv
// Directed bench for matrix_vector_loader at default 2x2 / 8-bit geometry.
module tb_matrix_vector_loader;
  import mvm_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  elem_t in_data;
  logic  in_valid, in_last, in_ready;
  mat_t  mat;
  vec_t  vec;
  logic  out_valid, out_ready, frame_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  matrix_vector_loader #(.DATA_WIDTH(8), .MAT_ROW(2), .MAT_COL(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mat(mat), .vec(vec), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic mat_t mk_mat(input int a, input int b, input int c, input int d);
    mat_t m;
    m[0][0] = elem_t'(a); m[0][1] = elem_t'(b);
    m[1][0] = elem_t'(c); m[1][1] = elem_t'(d);
    return m;
  endfunction

  function automatic vec_t mk_vec(input int a, input int b);
    vec_t v;
    v[0] = elem_t'(a); v[1] = elem_t'(b);
    return v;
  endfunction

  // Six back-to-back beats, first + stride*i, in_last on the sixth; assumes LOAD_MAT at entry
  task automatic send_frame(input int first, input int stride);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = elem_t'(first + stride * i);
      in_last = (i == 5);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (mat !== '0 || vec !== '0) begin failures++; $display("FAIL reset_operands: got mat=%h vec=%h expected 0", mat, vec); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] r0, r1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = elem_t'(i + 1);
      in_last = (i == 5);
      step();
      if (i < 5) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_early beat %0d: got %b expected 0", i, out_valid); end
      end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_frame_err beat %0d: got %b expected 0", i, frame_err); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_ov_cycle7: got %b expected 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_hold: got %b expected 0", in_ready); end
    checks++; if (mat !== mk_mat(1, 2, 3, 4)) begin failures++; $display("FAIL basic_mat: got %h expected %h", mat, mk_mat(1, 2, 3, 4)); end
    checks++; if (vec !== mk_vec(5, 6)) begin failures++; $display("FAIL basic_vec: got %h expected %h", vec, mk_vec(5, 6)); end
    r0 = mat[0][0] * vec[0] + mat[0][1] * vec[1];
    r1 = mat[1][0] * vec[0] + mat[1][1] * vec[1];
    checks++; if (r0 !== 8'd17 || r1 !== 8'd39) begin failures++; $display("FAIL basic_res: got %0d,%0d expected 17,39", r0, r1); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_ov_one_cycle: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready_back: got %b expected 1", in_ready); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_frame(1, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_ov_rise: got %b expected 1", out_valid); end
    in_valid = 1'b1; in_data = 8'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold cycle %0d: got ov=%b ir=%b expected ov=1 ir=0", i, out_valid, in_ready); end
      checks++; if (mat !== mk_mat(1, 2, 3, 4) || vec !== mk_vec(5, 6)) begin failures++; $display("FAIL bp_stable cycle %0d: got mat=%h vec=%h expected %h %h", i, mat, vec, mk_mat(1, 2, 3, 4), mk_vec(5, 6)); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready); end
    checks++; if (mat !== mk_mat(1, 2, 3, 4)) begin failures++; $display("FAIL bp_no_7th_beat: got %h expected %h", mat, mk_mat(1, 2, 3, 4)); end
    send_frame(7, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_frame2_ov: got %b expected 1", out_valid); end
    checks++; if (mat !== mk_mat(7, 8, 9, 10) || vec !== mk_vec(11, 12)) begin failures++; $display("FAIL bp_frame2_data: got mat=%h vec=%h expected %h %h", mat, vec, mk_mat(7, 8, 9, 10), mk_vec(11, 12)); end
    step();
  endtask

  task automatic test_bubbles();
    int vpat [12];
    int acc;
    int exp_cnt;
    vpat = '{1, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1};
    acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = (vpat[i] != 0);
      in_data  = (vpat[i] != 0) ? elem_t'(acc + 1) : 8'hEE;
      in_last  = (vpat[i] != 0) && (acc == 5);
      step();
      if (vpat[i] != 0) acc++;
      exp_cnt = (acc < 4) ? acc : ((acc < 6) ? acc - 4 : 0);
      checks++; if (dut.cnt_q !== 3'(exp_cnt)) begin failures++; $display("FAIL bub_cnt step %0d: got %0d expected %0d", i, dut.cnt_q, exp_cnt); end
      checks++; if (out_valid !== (acc == 6)) begin failures++; $display("FAIL bub_ov step %0d: got %b expected %b", i, out_valid, acc == 6); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (mat !== mk_mat(1, 2, 3, 4) || vec !== mk_vec(5, 6)) begin failures++; $display("FAIL bub_data: got mat=%h vec=%h expected %h %h", mat, vec, mk_mat(1, 2, 3, 4), mk_vec(5, 6)); end
    step();
  endtask

  task automatic test_framing();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = elem_t'(i + 1);
      in_last = (i == 2);
      step();
      checks++; if (frame_err !== ((i == 2) || (i == 5))) begin failures++; $display("FAIL fr_err beat %0d: got %b expected %b", i, frame_err, (i == 2) || (i == 5)); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fr_complete: got %b expected 1", out_valid); end
    checks++; if (mat !== mk_mat(1, 2, 3, 4) || vec !== mk_vec(5, 6)) begin failures++; $display("FAIL fr_data: got mat=%h vec=%h expected %h %h", mat, vec, mk_mat(1, 2, 3, 4), mk_vec(5, 6)); end
    step();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL fr_pulse_width: got %b expected 0", frame_err); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = elem_t'(i + 1);
      in_last = 1'b0;
      step();
    end
    rst_n = 1'b0; in_data = 8'h55;
    step();
    checks++; if (mat !== '0 || vec !== '0) begin failures++; $display("FAIL rmid_clear: got mat=%h vec=%h expected 0", mat, vec); end
    checks++; if (dut.state_q !== LOAD_MAT || dut.cnt_q !== 3'd0) begin failures++; $display("FAIL rmid_state: got st=%0d cnt=%0d expected 0 0", dut.state_q, dut.cnt_q); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rmid_flags: got ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid); end
    rst_n = 1'b1; in_valid = 1'b0;
    send_frame(9, -1);
    checks++; if (mat !== mk_mat(9, 8, 7, 6) || vec !== mk_vec(5, 4)) begin failures++; $display("FAIL rmid_frame: got mat=%h vec=%h expected %h %h", mat, vec, mk_mat(9, 8, 7, 6), mk_vec(5, 4)); end
    step();
  endtask

  task automatic test_reset_hold();
    out_ready = 1'b0;
    send_frame(1, 1);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rhold_pre: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rhold_flags: got ov=%b ir=%b expected ov=0 ir=1", out_valid, in_ready); end
    checks++; if (mat !== '0 || vec !== '0) begin failures++; $display("FAIL rhold_clear: got mat=%h vec=%h expected 0", mat, vec); end
    rst_n = 1'b1; out_ready = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_framing();
    test_reset_mid();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
